// File: rtl/writer.sv
// writer: turns single-cycle byte strobes from the data router into 4-phase
// request/acknowledge handshakes on the chip pins. Bytes are buffered in a
// small FIFO; the host acknowledge is synchronised before the FSM uses it.
//
// Ports:
//   clk                 single clock, all state changes on the rising edge
//   rst                 synchronous active-high reset
//   output_byte_pulsed  byte to send, valid while output_byte_pulse is high
//   output_byte_pulse   one byte per high cycle
//   output_ack          host acknowledge (asynchronous to clk)
//   output_byte         byte on the pins, held from launch to next launch
//   output_request      high while output_byte is offered to the host
//   fifo_count          bytes queued, not counting the byte on the pins
//   overflow            sticky: a byte was dropped because the FIFO was full
//   writer_busy         FIFO non-empty or handshake in progress
module writer #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    output_byte_pulsed,
  input  logic                          output_byte_pulse,
  input  logic                          output_ack,
  output logic [7:0]                    output_byte,
  output logic                          output_request,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic                          writer_busy
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {
    W_IDLE,
    W_REQ,
    W_RELEASE
  } state_e;

  state_e         state_q, state_d;
  logic           ack_meta_q, ack_s_q;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q, ovf_d;
  logic [7:0]     byte_q, byte_d;

  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;
  logic           push;

  // Two-flop synchroniser for the host acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_meta_q <= 1'b0;
      ack_s_q    <= 1'b0;
    end else begin
      ack_meta_q <= output_ack;
      ack_s_q    <= ack_meta_q;
    end
  end

  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // A launch pops the head; a stale (still high) acknowledge blocks it.
  assign pop  = (state_q == W_IDLE) && !fifo_empty && !ack_s_q;
  // A full FIFO still accepts a byte when the head leaves on the same edge.
  // An empty FIFO never pops, so there is no bypass to the pins.
  assign push = output_byte_pulse && (!fifo_full || pop);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= W_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      W_IDLE:    if (pop)      state_d = W_REQ;
      W_REQ:     if (ack_s_q)  state_d = W_RELEASE;
      W_RELEASE: if (!ack_s_q) state_d = W_IDLE;
      default:                 state_d = W_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    output_request = (state_q == W_REQ);
    writer_busy    = !fifo_empty || (state_q != W_IDLE);
  end

  // FIFO and pin-register next state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    byte_d   = byte_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
      byte_d   = mem_q[rd_ptr_q];
    end
    if (output_byte_pulse && !push) begin
      ovf_d = 1'b1;
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      byte_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      byte_q   <= byte_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= output_byte_pulsed;
    end
  end

  assign output_byte = byte_q;
  assign fifo_count  = count_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_writer.sv
// Testbench for writer: directed scenarios plus a randomised run, all checked
// against a queue-based reference model of the byte stream and handshake.
module tb_writer;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din;
  logic       pulse;
  logic       ack;
  logic [7:0] output_byte;
  logic       output_request;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       writer_busy;

  writer #(.FIFO_DEPTH(D)) dut (
    .clk                (clk),
    .rst                (rst),
    .output_byte_pulsed (din),
    .output_byte_pulse  (pulse),
    .output_ack         (ack),
    .output_byte        (output_byte),
    .output_request     (output_request),
    .fifo_count         (fifo_count),
    .overflow           (overflow),
    .writer_busy        (writer_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queued bytes, pin byte, handshake phase
  // (0 idle, 1 requesting, 2 waiting for ack release), ack sync stages.
  logic [7:0] mq[$];
  logic [7:0] m_byte;
  int         m_phase;
  logic       m_a1, m_a2, m_ovf;

  logic [7:0] got[$];
  bit         drain_to;

  // Drive one cycle of inputs, advance one edge, update the model,
  // return 1 time unit after the edge.
  task automatic step(input logic p, input logic [7:0] b, input logic a, input logic r);
    bit launch;
    rst = r; pulse = p; din = b; ack = a;
    @(posedge clk);
    if (r) begin
      mq.delete();
      m_byte = 8'h00; m_phase = 0; m_a1 = 0; m_a2 = 0; m_ovf = 0;
    end else begin
      launch = (m_phase == 0) && (mq.size() != 0) && !m_a2;
      if (launch)                    m_phase = 1;
      else if (m_phase == 1 && m_a2) m_phase = 2;
      else if (m_phase == 2 && !m_a2) m_phase = 0;
      if (launch) m_byte = mq.pop_front();
      if (p) begin
        if (mq.size() < D) mq.push_back(b);
        else               m_ovf = 1;
      end
      m_a2 = m_a1;
      m_a1 = a;
    end
    #1;
  endtask

  // Well-behaved host: acknowledge follows request. Collects delivered bytes.
  task automatic drain();
    logic a;
    int   guard;
    a = 1'b0; guard = 0;
    got.delete();
    while ((writer_busy || output_request || a) && guard < 300) begin
      if (output_request && !a) got.push_back(output_byte);
      a = output_request;
      step(0, 8'h00, a, 0);
      guard++;
    end
    drain_to = (guard >= 300);
  endtask

  task automatic test_reset();
    step(0, 8'h00, 0, 1);
    step(1, 8'h5A, 0, 1);
    n_cmp++; if (output_byte !== 8'h00) begin n_bad++; $display("FAIL reset_byte got %h want 00", output_byte); end
    n_cmp++; if (output_request !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b want 0", output_request); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL reset_count got %0d want 0", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_ovf got %b want 0", overflow); end
    n_cmp++; if (writer_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", writer_busy); end
    step(0, 8'h00, 0, 0);
  endtask

  task automatic test_single_byte();
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0);
    step(1, 8'hA5, 0, 0);
    n_cmp++; if (output_request !== 1'b0) begin n_bad++; $display("FAIL single_nobypass req got %b want 0", output_request); end
    n_cmp++; if (fifo_count !== 3'd1) begin n_bad++; $display("FAIL single_queued count got %0d want 1", fifo_count); end
    step(0, 8'h00, 0, 0);
    n_cmp++; if (output_request !== 1'b1) begin n_bad++; $display("FAIL single_req got %b want 1", output_request); end
    n_cmp++; if (output_byte !== 8'hA5) begin n_bad++; $display("FAIL single_byte got %h want a5", output_byte); end
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    n_cmp++; if (output_request !== 1'b1) begin n_bad++; $display("FAIL single_req_hold got %b want 1", output_request); end
    step(0, 8'h00, 1, 0);
    n_cmp++; if (output_request !== 1'b0) begin n_bad++; $display("FAIL single_req_fall got %b want 0", output_request); end
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    n_cmp++; if (writer_busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_release got %b want 1", writer_busy); end
    step(0, 8'h00, 0, 0);
    n_cmp++; if (writer_busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_idle got %b want 0", writer_busy); end
    n_cmp++; if (output_byte !== 8'hA5) begin n_bad++; $display("FAIL single_byte_stable got %h want a5", output_byte); end
  endtask

  task automatic test_burst();
    for (int i = 1; i <= 4; i++) step(1, 8'(i), 0, 0);
    n_cmp++; if (fifo_count !== 3'd3) begin n_bad++; $display("FAIL burst_peak got %0d want 3", fifo_count); end
    n_cmp++; if (output_byte !== 8'h01) begin n_bad++; $display("FAIL burst_pins got %h want 01", output_byte); end
    drain();
    n_cmp++; if (drain_to) begin n_bad++; $display("FAIL burst_timeout got 1 want 0"); end
    n_cmp++; if (got.size() !== 4) begin n_bad++; $display("FAIL burst_len got %0d want 4", got.size()); end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      n_cmp++; if (got[i] !== 8'(i + 1)) begin n_bad++; $display("FAIL burst_order[%0d] got %h want %h", i, got[i], 8'(i + 1)); end
    end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL burst_ovf got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 6; i++) step(1, 8'h10 + 8'(i), 0, 0);
    n_cmp++; if (output_byte !== 8'h10) begin n_bad++; $display("FAIL ovf_pins got %h want 10", output_byte); end
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL ovf_count got %0d want 4", fifo_count); end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", overflow); end
    drain();
    n_cmp++; if (drain_to) begin n_bad++; $display("FAIL ovf_timeout got 1 want 0"); end
    n_cmp++; if (got.size() !== 5) begin n_bad++; $display("FAIL ovf_len got %0d want 5", got.size()); end
    for (int i = 0; i < got.size() && i < 5; i++) begin
      n_cmp++; if (got[i] !== 8'h10 + 8'(i)) begin n_bad++; $display("FAIL ovf_order[%0d] got %h want %h", i, got[i], 8'h10 + 8'(i)); end
    end
    n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_full_with_pop();
    step(0, 8'h00, 1, 1);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 1, 0);
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL fwp_filled got %0d want 4", fifo_count); end
    n_cmp++; if (output_request !== 1'b0) begin n_bad++; $display("FAIL fwp_held req got %b want 0", output_request); end
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    step(1, 8'hEE, 0, 0);
    n_cmp++; if (fifo_count !== 3'd4) begin n_bad++; $display("FAIL fwp_count got %0d want 4", fifo_count); end
    n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL fwp_ovf got %b want 0", overflow); end
    n_cmp++; if (output_byte !== 8'hA0) begin n_bad++; $display("FAIL fwp_pins got %h want a0", output_byte); end
    drain();
    n_cmp++; if (drain_to) begin n_bad++; $display("FAIL fwp_timeout got 1 want 0"); end
    n_cmp++; if (got.size() !== 5) begin n_bad++; $display("FAIL fwp_len got %0d want 5", got.size()); end
    n_cmp++; if (got.size() == 5 && got[4] !== 8'hEE) begin n_bad++; $display("FAIL fwp_last got %h want ee", got[4]); end
  endtask

  task automatic test_stale_ack();
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 1, 0);
    step(1, 8'h3C, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 8'h00, 1, 0);
      n_cmp++; if (output_request !== 1'b0) begin n_bad++; $display("FAIL stale_req[%0d] got %b want 0", i, output_request); end
    end
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 0, 0);
    n_cmp++; if (output_request !== 1'b0) begin n_bad++; $display("FAIL stale_sync req got %b want 0", output_request); end
    step(0, 8'h00, 0, 0);
    n_cmp++; if (output_request !== 1'b1) begin n_bad++; $display("FAIL stale_launch req got %b want 1", output_request); end
    n_cmp++; if (output_byte !== 8'h3C) begin n_bad++; $display("FAIL stale_byte got %h want 3c", output_byte); end
    drain();
  endtask

  task automatic test_reset_mid();
    step(1, 8'h51, 0, 0);
    step(1, 8'h52, 0, 0);
    step(1, 8'h53, 0, 0);
    n_cmp++; if (output_request !== 1'b1 || fifo_count !== 3'd2) begin n_bad++; $display("FAIL rstmid_setup req/count got %b/%0d want 1/2", output_request, fifo_count); end
    step(1, 8'h99, 0, 1);
    n_cmp++; if (output_request !== 1'b0) begin n_bad++; $display("FAIL rstmid_req got %b want 0", output_request); end
    n_cmp++; if (fifo_count !== 3'd0) begin n_bad++; $display("FAIL rstmid_count got %0d want 0", fifo_count); end
    n_cmp++; if (output_byte !== 8'h00) begin n_bad++; $display("FAIL rstmid_byte got %h want 00", output_byte); end
    n_cmp++; if (writer_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy got %b want 0", writer_busy); end
    step(1, 8'h77, 0, 0);
    drain();
    n_cmp++; if (got.size() !== 1 || got[0] !== 8'h77) begin n_bad++; $display("FAIL rstmid_first got size %0d byte %h want 1 77", got.size(), (got.size() > 0) ? got[0] : 8'h00); end
  endtask

  task automatic test_random();
    logic       p, a, r;
    logic [7:0] b;
    bit         m_busy;
    a = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      p = ($urandom_range(0, 2) != 0);
      b = 8'($urandom);
      if ($urandom_range(0, 3) == 0) a = ~a;
      r = ($urandom_range(0, 299) == 0);
      step(p, b, a, r);
      m_busy = (mq.size() != 0) || (m_phase != 0);
      n_cmp++; if (output_byte !== m_byte) begin n_bad++; $display("FAIL rnd_byte c%0d got %h want %h", c, output_byte, m_byte); end
      n_cmp++; if (output_request !== (m_phase == 1)) begin n_bad++; $display("FAIL rnd_req c%0d got %b want %b", c, output_request, m_phase == 1); end
      n_cmp++; if (fifo_count !== 3'(mq.size())) begin n_bad++; $display("FAIL rnd_count c%0d got %0d want %0d", c, fifo_count, mq.size()); end
      n_cmp++; if (overflow !== m_ovf) begin n_bad++; $display("FAIL rnd_ovf c%0d got %b want %b", c, overflow, m_ovf); end
      n_cmp++; if (writer_busy !== m_busy) begin n_bad++; $display("FAIL rnd_busy c%0d got %b want %b", c, writer_busy, m_busy); end
    end
  endtask

  initial begin
    rst = 1'b1; pulse = 1'b0; din = 8'h00; ack = 1'b0;
    m_byte = 8'h00; m_phase = 0; m_a1 = 0; m_a2 = 0; m_ovf = 0;
    test_reset();
    test_single_byte();
    test_burst();
    test_overflow();
    test_full_with_pop();
    test_stale_ack();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/writer.md
WRITER -- requirements
Module: writer

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, number of queued output bytes (power of two, >= 2).
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: output_byte_pulsed  input  8  cipher output byte; valid only while output_byte_pulse is high.
REQ-005 Port: output_byte_pulse  input  1  single-cycle strobe from the data router; one byte per high cycle.
REQ-006 Port: output_ack  input  1  chip-pin acknowledge from the host; asynchronous to clk.
REQ-007 Port: output_byte  output  8  byte presented on the chip pins.
REQ-008 Port: output_request  output  1  chip-pin request; high means output_byte is valid.
REQ-009 Port: fifo_count  output  $clog2(FIFO_DEPTH)+1  number of bytes queued, excluding the byte on the pins.
REQ-010 Port: overflow  output  1  sticky flag; a byte was dropped because the FIFO was full.
REQ-011 Port: writer_busy  output  1  high when the FIFO is non-empty or the FSM is not in W_IDLE.

Function
REQ-012 The block SHALL convert each output_byte_pulse into one 4-phase handshake on output_request/output_ack. It is the transmit-side counterpart of the pulse-generating input reader.
REQ-013 output_ack SHALL pass through a 2-flop synchronizer, producing ack_s. The FSM SHALL use only ack_s.
REQ-014 Push: on an edge where output_byte_pulse=1, the block SHALL write output_byte_pulsed at the write pointer and increment the write pointer (modulo FIFO_DEPTH), provided the FIFO is not full or a pop occurs on the same edge.
REQ-015 Full drop: if output_byte_pulse=1 while the FIFO is full and no pop occurs that edge, the byte SHALL be discarded, overflow SHALL be set, and pointers and count SHALL be unchanged.
REQ-016 overflow SHALL stay high until rst.
REQ-017 Simultaneous push and pop SHALL leave fifo_count unchanged and advance both pointers.
REQ-018 FSM states SHALL be W_IDLE, W_REQ, W_RELEASE; the reset state is W_IDLE.
REQ-019 W_IDLE -> W_REQ when FIFO non-empty and ack_s=0. On that edge the block SHALL load output_byte from the FIFO head, pop the head, and set output_request=1.
REQ-020 W_IDLE SHALL not launch while ack_s=1 (stale acknowledge is ignored).
REQ-021 W_REQ -> W_RELEASE when ack_s=1. On that edge output_request SHALL go to 0.
REQ-022 W_RELEASE -> W_IDLE when ack_s=0. A new launch is possible on the following edge.
REQ-023 output_byte SHALL be stable from the launch edge until the next launch edge.
REQ-024 Latency: with the FIFO empty and the FSM in W_IDLE, a pulse sampled at edge E SHALL produce output_request=1 after edge E+1. There is no bypass path.
REQ-025 Acknowledge latency: output_request SHALL fall on the third edge after output_ack first meets setup high (two synchronizer edges plus the FSM edge).
REQ-026 Changes of output_ack in W_REQ before ack_s=1, or in W_RELEASE before ack_s=0, SHALL cause no other state change.
REQ-027 Ordering: bytes SHALL appear on output_byte in strict push order; no byte is duplicated or skipped except drops under REQ-015.
REQ-028 fifo_count SHALL range from 0 to FIFO_DEPTH and SHALL never wrap.

Reset
REQ-029 While rst=1 at an edge, the block SHALL set output_byte=8'h00, output_request=0, fifo_count=0, overflow=0, writer_busy=0, state=W_IDLE, pointers=0, and synchronizer flops=0.
REQ-030 rst asserted mid-handshake SHALL drop output_request on that edge and discard all queued bytes. Pulses arriving while rst=1 SHALL be ignored.

Verification
REQ-031 Single byte: pulse 8'hA5 at edge 10 with the host acking 2 cycles after request -> output_request=1 after edge 11, output_byte=8'hA5, request falls 3 edges after ack, writer_busy=0 after W_RELEASE exits.
REQ-032 Burst: pulses 8'h01..8'h04 on 4 consecutive cycles with the host stalled -> fifo_count peaks at 3 (8'h01 on the pins), overflow=0, and bytes are delivered in order 01,02,03,04.
REQ-033 Overflow: 6 consecutive pulses 8'h10..8'h15 with the host stalled -> 8'h10 on the pins, 8'h11..8'h14 queued, 8'h15 dropped, overflow=1 and remaining 1 after the drain completes.
REQ-034 Full with pop: FIFO full and the FSM launching on the same edge as pulse 8'hEE -> 8'hEE accepted, fifo_count stays at 4, overflow=0.
REQ-035 Stale ack: output_ack held high in W_IDLE while pulse 8'h3C arrives -> no request until ack_s=0, then the launch proceeds.
REQ-036 Reset mid-operation: rst during W_REQ with 2 bytes queued -> all outputs zero next edge, subsequent pulse 8'h77 delivered as the first byte.
